// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   FETCH_* defaults : PC / memory-address / instruction widths
//   FETCH_RESET_PC   : first fetch address after reset (word aligned)
//   PC_INC           : sequential PC step in bytes
//   fetch_state_e    : RUN/HOLD state of the decode-side hold buffer
package fetch_unit_pkg;

  localparam int unsigned FETCH_PC_WIDTH       = 32;
  localparam int unsigned FETCH_MEM_ADDR_WIDTH = 10;
  localparam int unsigned FETCH_DATA_WIDTH     = 32;
  localparam logic [31:0] FETCH_RESET_PC       = 32'h0000_0000;
  localparam int unsigned PC_INC               = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer between program memory and decode.
// Captures the memory word when decode stalls, since the memory output
// moves on to the next address, and muxes the presented instruction.
//   redirect  : drop any held word and return to RUN
//   stall     : decode cannot accept the presented instruction
//   rsp_valid : mem_rdata carries a live word for rsp_pc
//   rsp_pc    : PC of the word currently on mem_rdata
//   mem_rdata : program memory read data
//   if_valid / if_pc / if_instr : instruction presented to decode
module fetch_hold_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = FETCH_PC_WIDTH,
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect,
  input  logic                  stall,
  input  logic                  rsp_valid,
  input  logic [PC_WIDTH-1:0]   rsp_pc,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  if_valid,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
);

  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] hold_instr_q;

  // RUN/HOLD state and capture of the stalled word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      hold_instr_q <= '0;
    end else if (redirect) begin
      state <= ST_RUN;
    end else if (state == ST_HOLD) begin
      if (!stall) state <= ST_RUN;
    end else if (rsp_valid && stall) begin
      hold_instr_q <= mem_rdata;
      state        <= ST_HOLD;
    end
  end

  // Present the held word while in HOLD, otherwise the live memory word
  always_comb begin
    if_valid = rsp_valid;
    if_instr = mem_rdata;
    if (state == ST_HOLD) begin
      if_valid = 1'b1;
      if_instr = hold_instr_q;
    end
  end

  assign if_pc = rsp_pc;

endmodule : fetch_hold_buf

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues byte addresses to a 1-cycle-latency
// program memory, pairs returned words with their PC and presents them
// to decode with a valid/stall handshake. Execute redirects win over stall.
//   redirect_valid / redirect_pc : PC change request (low bits forced to 0)
//   stall        : decode cannot accept the presented instruction
//   mem_addr     : byte address to program memory (low bits of pc_q)
//   mem_rdata    : word for the address issued at the previous edge
//   if_valid / if_pc / if_instr : instruction presented to decode
//   misalign_err : one-cycle pulse after a misaligned redirect target
//   fetch_count  : instructions accepted by decode (wraps)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH       = FETCH_PC_WIDTH,
  parameter int unsigned         MEM_ADDR_WIDTH = FETCH_MEM_ADDR_WIDTH,
  parameter int unsigned         DATA_WIDTH     = FETCH_DATA_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = PC_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [PC_WIDTH-1:0]       redirect_pc,
  input  logic                      stall,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      if_valid,
  output logic [PC_WIDTH-1:0]       if_pc,
  output logic [DATA_WIDTH-1:0]     if_instr,
  output logic                      misalign_err,
  output logic [31:0]               fetch_count
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] rsp_pc_q;
  logic                rsp_valid_q;
  logic                misalign_q;
  logic [31:0]         count_q;
  logic                accept;
  logic                advance;

  assign accept  = if_valid && !stall;
  // Only a stalled live instruction freezes the issue pointer
  assign advance = !(if_valid && stall);

  // Issue pointer, response tracking and redirect handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (redirect_valid) begin
      // The word already in flight belongs to the old path: drop it
      pc_q        <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      rsp_valid_q <= 1'b0;
      misalign_q  <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_q <= 1'b0;
      if (advance) begin
        rsp_pc_q    <= pc_q;
        rsp_valid_q <= 1'b1;
        pc_q        <= pc_q + PC_WIDTH'(PC_INC);
      end
    end
  end

  // Accepted-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_q + 32'(accept);
  end

  fetch_hold_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .redirect  (redirect_valid),
    .stall     (stall),
    .rsp_valid (rsp_valid_q),
    .rsp_pc    (rsp_pc_q),
    .mem_rdata (mem_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr)
  );

  assign mem_addr     = pc_q[MEM_ADDR_WIDTH-1:0];
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table for the documented
// corner cases, reset-during-HOLD sequence, then randomized stall/redirect
// traffic checked against a presentation-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Presentation model: what decode sees, not how the RTL builds it
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic [31:0] m_count;
  logic        m_mis;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [9:0]  e_addr;
    logic        e_mis;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[18];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 256-word program memory, word i = 0x1000_0000 + i, one-cycle read latency
  always_ff @(posedge clk) mem_rdata <= 32'h1000_0000 + 32'(mem_addr[9:2]);

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[9:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_next  = 32'h0;
    m_count = 32'h0;
    m_mis   = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic st);
    if (m_valid && !st) m_count = m_count + 32'd1;
    m_mis = rv && (rpc[1:0] != 2'b00);
    if (rv) begin
      m_valid = 1'b0;
      m_next  = {rpc[31:2], 2'b00};
    end else if (m_valid && st) begin
      // decode keeps seeing the same instruction
    end else if (m_valid) begin
      m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b1;
      m_pc    = m_next;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_addr;
    exp_addr = m_valid ? (m_pc + 32'd4) : m_next;
    chk({tag, " if_valid"}, 32'(if_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, " if_pc"}, if_pc, m_pc);
      chk({tag, " if_instr"}, if_instr, word_at(m_pc));
    end
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr[9:0]));
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'(m_mis));
    chk({tag, " fetch_count"}, fetch_count, m_count);
  endtask

  // Drive inputs at the falling edge, advance one clock, sample at next fall
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic st);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    @(posedge clk);
    model_step(rv, rpc, st);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    model_reset();

    //            rv    rpc           st    vld   pc            instr          addr     mis   count
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1000_0000, 10'h004, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        32'h1000_0001, 10'h008, 1'b0, 32'd1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h1000_0002, 10'h00C, 1'b0, 32'd2};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h1000_0002, 10'h00C, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h1000_0002, 10'h00C, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h1000_0002, 10'h00C, 1'b0, 32'd2};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        32'h1000_0003, 10'h010, 1'b0, 32'd3};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       32'h1000_0004, 10'h014, 1'b0, 32'd4};
    vecs[8]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        32'h0,         10'h040, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h40,       32'h1000_0010, 10'h044, 1'b0, 32'd5};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h44,       32'h1000_0011, 10'h048, 1'b0, 32'd6};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       32'h1000_0011, 10'h048, 1'b0, 32'd6};
    vecs[12] = '{1'b1, 32'h42,       1'b1, 1'b0, 32'h0,        32'h0,         10'h040, 1'b1, 32'd6};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'h1000_0010, 10'h044, 1'b0, 32'd6};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h44,       32'h1000_0011, 10'h048, 1'b0, 32'd7};
    vecs[15] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       32'h0,         10'h3FC, 1'b0, 32'd8};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1000_00FF, 10'h000, 1'b0, 32'd8};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1000_0000, 10'h004, 1'b0, 32'd9};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset if_valid", 32'(if_valid), 32'h0);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset misalign_err", 32'(misalign_err), 32'h0);
    chk("reset fetch_count", fetch_count, 32'h0);
    rst_n = 1'b1;
    // First cycle after release: nothing presented yet
    chk("release if_valid", 32'(if_valid), 32'h0);

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].rv, vecs[i].rpc, vecs[i].st);
      chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d if_instr", i), if_instr, vecs[i].e_instr);
      end
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].e_count);
    end

    // Reset asserted while holding a stalled instruction
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check_model("pre-reset hold");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midhold reset if_valid", 32'(if_valid), 32'h0);
    chk("midhold reset if_pc", if_pc, 32'h0);
    chk("midhold reset mem_addr", 32'(mem_addr), 32'h0);
    chk("midhold reset fetch_count", fetch_count, 32'h0);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    check_model("restart c1");
    cycle(1'b0, 32'h0, 1'b0);
    check_model("restart c2");
    cycle(1'b0, 32'h0, 1'b0);
    check_model("restart c3");

    // Randomized stall/redirect traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic        st;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 99) < 8);
      st  = ($urandom_range(0, 99) < 35);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      cycle(rv, rpc, st);
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
